// File: rtl/style_color_resolve_sched_if.sv
// Request/datapath/response bundle for style_color_resolve_sched.
//   req_*  : per-requester property issue (packed, requester i at slice i)
//   dp_*   : operand out to / color back from the shared color datapath
//   rsp_*  : resolved color back to the issuer, valid/ready handshake
// slave  : the scheduler side; master : issuers + datapath side.
interface style_color_resolve_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 10,
  parameter int UTW  = 7,
  parameter int CW   = 32
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]     req_valid;
  logic [NREQ*IDW-1:0] req_ident;
  logic [NREQ*UTW-1:0] req_unit;
  logic [NREQ-1:0]     req_ready;

  logic                dp_valid;
  logic [31:0]         dp_ident;
  logic [CW-1:0]       dp_inherited;
  logic [CW-1:0]       dp_color;

  logic                rsp_valid;
  logic [IW-1:0]       rsp_id;
  logic [CW-1:0]       rsp_color;
  logic                rsp_ready;

  modport slave (
    input  req_valid, req_ident, req_unit, dp_color, rsp_ready,
    output req_ready, dp_valid, dp_ident, dp_inherited, rsp_valid, rsp_id, rsp_color
  );

  modport master (
    output req_valid, req_ident, req_unit, dp_color, rsp_ready,
    input  req_ready, dp_valid, dp_ident, dp_inherited, rsp_valid, rsp_id, rsp_color
  );
endinterface

// File: rtl/style_color_resolve_sched.sv
// Shares one combinational color-resolution datapath between NREQ style
// property requesters (requester 0 is always the element's color property).
// Round-robin arbitration; owns the element's inherited/current color that
// is fed to the datapath; holds back currentcolor requesters until the
// element's own color has resolved (when the element declares one).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   elem_start, parent_color new element pulse and the parent's color
//   color_declared           element declares its own color property
//   css_ident_type           unit code meaning "value is an ident"
//   css_value_currentcolor   ident code of currentcolor
//   bus (slave)              request / datapath / response signals
module style_color_resolve_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 10,
  parameter int UTW  = 7,
  parameter int CW   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    elem_start,
  input  logic [CW-1:0]           parent_color,
  input  logic                    color_declared,
  input  logic [UTW-1:0]          css_ident_type,
  input  logic [IDW-1:0]          css_value_currentcolor,
  style_color_resolve_sched_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]     state;
  logic [IW-1:0]  rrPtr;
  logic [IW-1:0]  grantIdx;
  logic [IW-1:0]  rspId;
  logic [CW-1:0]  inheritedColor;
  logic [CW-1:0]  rspColor;
  logic           colorDone;
  logic           elemPend;
  logic [IDW-1:0] opIdent;

  logic [NREQ-1:0] needsCc;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grantOh;
  logic [IW-1:0]   grantSel;
  logic            grantAny;
  logic            doGrant;
  logic [IW:0]     scan;

  always_comb begin
    needsCc  = '0;
    eligible = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      needsCc[i]  = (bus.req_unit[i*UTW +: UTW] == css_ident_type) &&
                    (bus.req_ident[i*IDW +: IDW] == css_value_currentcolor);
      eligible[i] = bus.req_valid[i] &&
                    (i == 0 || !needsCc[i] || colorDone || !color_declared);
    end
  end

  // Scan one extra bit wide so the wrap is correct when NREQ is not a power of two.
  always_comb begin
    grantAny = 1'b0;
    grantSel = '0;
    scan     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan = {1'b0, rrPtr} + (IW+1)'(k);
      if (scan >= (IW+1)'(NREQ)) scan = scan - (IW+1)'(NREQ);
      if (!grantAny && eligible[scan[IW-1:0]]) begin
        grantAny = 1'b1;
        grantSel = scan[IW-1:0];
      end
    end
  end

  // A new element (fresh or pending) takes the IDLE cycle; nothing is granted then.
  assign doGrant = !rst && (state == IDLE) && !elem_start && !elemPend && grantAny;

  always_comb begin
    grantOh = '0;
    if (doGrant) grantOh[grantSel] = 1'b1;
  end

  assign bus.req_ready    = grantOh;
  assign bus.dp_valid     = (state == ISSUE);
  assign bus.dp_ident     = (state == ISSUE) ? 32'(opIdent) : '0;
  assign bus.dp_inherited = inheritedColor;
  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = rspId;
  assign bus.rsp_color    = rspColor;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rrPtr          <= '0;
      grantIdx       <= '0;
      rspId          <= '0;
      inheritedColor <= '0;
      rspColor       <= '0;
      colorDone      <= 1'b0;
      elemPend       <= 1'b0;
      opIdent        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (elem_start || elemPend) begin
            inheritedColor <= parent_color;
            colorDone      <= 1'b0;
            elemPend       <= 1'b0;
          end else if (grantAny) begin
            // Non-ident values reach the datapath as ident 0.
            opIdent  <= (bus.req_unit[grantSel*UTW +: UTW] == css_ident_type) ?
                        bus.req_ident[grantSel*IDW +: IDW] : '0;
            grantIdx <= grantSel;
            rrPtr    <= (grantSel == IW'(NREQ-1)) ? '0 : grantSel + 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          rspColor <= bus.dp_color;
          rspId    <= grantIdx;
          if (elem_start) elemPend <= 1'b1;
          state    <= RESP;
        end
        RESP: begin
          // A requester-0 handshake lands before any pending elem_start is applied in IDLE.
          if (elem_start) elemPend <= 1'b1;
          if (bus.rsp_ready) begin
            if (rspId == '0) begin
              inheritedColor <= rspColor;
              colorDone      <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
